// File: rtl/alu_control.sv
// ALU-stage instruction decode: maps the 4-bit ALU opcode to the eight datapath
// control lines, an activity flag, and two glitch-free gated copies of the clock.

module alu_control (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Pipe1Out_4_ALUOP0,
    input  logic Pipe1Out_5_ALUOP1,
    input  logic Pipe1Out_6_ALUOP2,
    input  logic Pipe1Out_7_ALUOP3,
    output logic AluClock_bufgce,
    output logic AluClock_and,
    output logic AluActive,
    output logic AC0_RHS0,
    output logic AC1_RHS1,
    output logic AC2_RHS2,
    output logic AC3_RHS3,
    output logic AC4_LHS0,
    output logic AC5_LHS1,
    output logic AC6_CS0,
    output logic AC7_CS1
);

    logic [3:0] op_s;
    logic [7:0] cw_s;
    logic       alu_active_s;
    logic       en_d;
    logic       en_q;

    assign op_s = {Pipe1Out_7_ALUOP3, Pipe1Out_6_ALUOP2, Pipe1Out_5_ALUOP1, Pipe1Out_4_ALUOP0};

    // Opcode decode; the activity flag comes from the same case so an unknown opcode
    // falls into the default and reads as a NOP on both outputs.
    always_comb begin
        cw_s         = 8'h00;
        alu_active_s = 1'b0;
        case (op_s)
            4'd1:    begin cw_s = 8'h1A; alu_active_s = 1'b1; end
            4'd2:    begin cw_s = 8'h9A; alu_active_s = 1'b1; end
            4'd3:    begin cw_s = 8'h55; alu_active_s = 1'b1; end
            4'd4:    begin cw_s = 8'h95; alu_active_s = 1'b1; end
            4'd5:    begin cw_s = 8'h50; alu_active_s = 1'b1; end
            4'd6:    begin cw_s = 8'h1F; alu_active_s = 1'b1; end
            4'd7:    begin cw_s = 8'h08; alu_active_s = 1'b1; end
            4'd8:    begin cw_s = 8'h0E; alu_active_s = 1'b1; end
            4'd9:    begin cw_s = 8'h06; alu_active_s = 1'b1; end
            4'd10:   begin cw_s = 8'h03; alu_active_s = 1'b1; end
            4'd11:   begin cw_s = 8'h1C; alu_active_s = 1'b1; end
            4'd12:   begin cw_s = 8'h9C; alu_active_s = 1'b1; end
            4'd13:   begin cw_s = 8'h20; alu_active_s = 1'b1; end
            4'd14:   begin cw_s = 8'hA0; alu_active_s = 1'b1; end
            4'd15:   begin cw_s = 8'hE0; alu_active_s = 1'b1; end
            default: begin cw_s = 8'h00; alu_active_s = 1'b0; end
        endcase
    end

    // Next value of the gate enable.
    always_comb begin
        en_d = alu_active_s;
    end

    // Enable is captured while Clock is low so the gated high phase is never cut short.
    always_ff @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    assign AluClock_and = Clock & en_q;

    alu_bufgce u_bufgce (
        .i  (Clock),
        .ce (en_q),
        .o  (AluClock_bufgce)
    );

    assign AluActive = alu_active_s;
    assign {AC7_CS1, AC6_CS0, AC5_LHS1, AC4_LHS0, AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0} = cw_s;

endmodule

// Behavioural stand-in for the FPGA clock-buffer-with-enable primitive; swap for the
// vendor cell at implementation.
module alu_bufgce (
    input  logic i,
    input  logic ce,
    output logic o
);

    assign o = i & ce;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: opcode table sweep, randomized opcodes against a
// reference model of the gated clock, and hand-written gating/reset corner cases.

module tb_alu_control;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] cw;
        logic       act;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] op;
    logic       g_bufgce, g_and, active;
    logic [7:0] cw;
    logic       model_en;
    logic       mon_on;
    int         total;
    int         bad;
    vec_t       vecs [16];

    alu_control dut (
        .Clock             (clk),
        .Reset_n           (rst_n),
        .Pipe1Out_4_ALUOP0 (op[0]),
        .Pipe1Out_5_ALUOP1 (op[1]),
        .Pipe1Out_6_ALUOP2 (op[2]),
        .Pipe1Out_7_ALUOP3 (op[3]),
        .AluClock_bufgce   (g_bufgce),
        .AluClock_and      (g_and),
        .AluActive         (active),
        .AC0_RHS0          (cw[0]),
        .AC1_RHS1          (cw[1]),
        .AC2_RHS2          (cw[2]),
        .AC3_RHS3          (cw[3]),
        .AC4_LHS0          (cw[4]),
        .AC5_LHS1          (cw[5]),
        .AC6_CS0           (cw[6]),
        .AC7_CS1           (cw[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        total = total + 1;
        if (act_v !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act_v, exp_v);
        end
    endtask

    task automatic check_gates(input string name, input logic exp_v);
        check({name, "_and"}, {7'd0, g_and}, {7'd0, exp_v});
        check({name, "_bufgce"}, {7'd0, g_bufgce}, {7'd0, exp_v});
    endtask

    task automatic mid_high();
        @(posedge clk);
        #2;
    endtask

    task automatic mid_low();
        @(negedge clk);
        #2;
    endtask

    // Reference model: a rising edge passes only if the last falling edge saw a
    // non-zero opcode out of reset; reset kills the gate immediately.
    always @(negedge clk) model_en = rst_n && (op != 4'd0);
    always @(negedge rst_n) model_en = 1'b0;

    always @(posedge clk) begin
        #1;
        if (mon_on) check_gates("gate_high", model_en);
    end

    always @(negedge clk) begin
        #1;
        if (mon_on) check_gates("gate_low", 1'b0);
    end

    initial begin
        total    = 0;
        bad      = 0;
        mon_on   = 1'b0;
        model_en = 1'b0;
        vecs[0]  = '{4'd0,  8'h00, 1'b0};
        vecs[1]  = '{4'd1,  8'h1A, 1'b1};
        vecs[2]  = '{4'd2,  8'h9A, 1'b1};
        vecs[3]  = '{4'd3,  8'h55, 1'b1};
        vecs[4]  = '{4'd4,  8'h95, 1'b1};
        vecs[5]  = '{4'd5,  8'h50, 1'b1};
        vecs[6]  = '{4'd6,  8'h1F, 1'b1};
        vecs[7]  = '{4'd7,  8'h08, 1'b1};
        vecs[8]  = '{4'd8,  8'h0E, 1'b1};
        vecs[9]  = '{4'd9,  8'h06, 1'b1};
        vecs[10] = '{4'd10, 8'h03, 1'b1};
        vecs[11] = '{4'd11, 8'h1C, 1'b1};
        vecs[12] = '{4'd12, 8'h9C, 1'b1};
        vecs[13] = '{4'd13, 8'hA0 ^ 8'h80, 1'b1};
        vecs[14] = '{4'd14, 8'hA0, 1'b1};
        vecs[15] = '{4'd15, 8'hE0, 1'b1};

        // In reset with ADD presented: decode live, gates held low.
        rst_n = 1'b0;
        op    = 4'd1;
        #1;
        mon_on = 1'b1;
        repeat (4) mid_high();
        check("reset_cw", cw, 8'h1A);
        check("reset_active", {7'd0, active}, 8'h01);
        check_gates("reset_gate", 1'b0);
        rst_n = 1'b1;
        #1;
        check_gates("release_gate", 1'b0);
        @(posedge clk);
        #1;
        check_gates("first_pulse", 1'b1);

        // Opcode table sweep, each value held five clocks.
        for (int i = 0; i < 16; i++) begin
            mid_high();
            op = vecs[i].op;
            #1;
            check($sformatf("cw_op%0d", i), cw, vecs[i].cw);
            check($sformatf("act_op%0d", i), {7'd0, active}, {7'd0, vecs[i].act});
            repeat (4) mid_high();
        end

        // NOP run, then XOR: pulses start after the next falling edge.
        mid_high();
        op = 4'd0;
        repeat (5) mid_high();
        op = 4'd9;
        #1;
        check_gates("nop_to_xor_now", 1'b0);
        @(posedge clk);
        #1;
        check_gates("nop_to_xor_next", 1'b1);

        // SUB to NOP mid-high: current pulse completes, next edge suppressed.
        mid_high();
        op = 4'd3;
        mid_high();
        check_gates("sub_pulse", 1'b1);
        op = 4'd0;
        #2;
        check_gates("sub_full_width", 1'b1);
        @(posedge clk);
        #1;
        check_gates("sub_then_nop", 1'b0);

        // Reset asserted mid-pulse with INC.
        mid_high();
        op = 4'd5;
        mid_high();
        check_gates("inc_pulse", 1'b1);
        rst_n = 1'b0;
        #1;
        check_gates("inc_reset_drop", 1'b0);
        repeat (3) mid_high();
        rst_n = 1'b1;
        #1;
        check_gates("inc_after_release", 1'b0);
        @(posedge clk);
        #1;
        check_gates("inc_resume", 1'b1);

        // Random opcodes changing in either clock phase.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 0) mid_high();
            else mid_low();
            op = 4'($urandom_range(15, 0));
            #1;
            check("rand_cw", cw, vecs[op].cw);
            check("rand_active", {7'd0, active}, {7'd0, (op != 4'd0)});
        end

        mid_high();
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
